// File: rtl/ps2_pkg.sv
// Shared PS/2 scancode constants, default key table entries and the
// make/break prefix decoder state type.
package ps2_pkg;

    localparam logic [7:0] SC_EXT = 8'hE0;
    localparam logic [7:0] SC_BRK = 8'hF0;

    // Key codes are {extended, scancode}.
    localparam logic [8:0] KC_UP    = 9'h175;
    localparam logic [8:0] KC_DOWN  = 9'h172;
    localparam logic [8:0] KC_SPACE = 9'h029;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_EXT     = 2'd1,
        ST_BRK     = 2'd2,
        ST_EXT_BRK = 2'd3
    } prefix_state_t;

    // Odd parity holds when data bits plus parity bit contain an odd count of ones.
    function automatic logic parity_ok(input logic [8:0] bits);
        return ^bits;
    endfunction

endpackage

// File: rtl/ps2_rx.sv
// PS/2 frame receiver: synchronises kb_clk/data, shifts in 11-bit frames,
// validates start/parity/stop and abandons frames that stall.
module ps2_rx
    import ps2_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 200000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       kb_clk,
    input  logic       data,
    output logic [7:0] rx_byte,
    output logic       byte_valid,
    output logic       frame_err
);

    localparam int TW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;

    logic [1:0]    kb_clk_sync_reg;
    logic [1:0]    data_sync_reg;
    logic          kb_clk_prev_reg;
    logic [9:0]    shift_reg;
    logic [3:0]    bit_cnt_reg;
    logic [TW-1:0] to_cnt_reg;
    logic [7:0]    byte_reg;
    logic          byte_valid_reg;
    logic          frame_err_reg;
    logic          fall;
    logic          bit_in;

    // Sync stages reset to the idle-high line level so reset release is not seen as an edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            kb_clk_sync_reg <= 2'b11;
            data_sync_reg   <= 2'b11;
            kb_clk_prev_reg <= 1'b1;
        end else begin
            kb_clk_sync_reg <= {kb_clk_sync_reg[0], kb_clk};
            data_sync_reg   <= {data_sync_reg[0], data};
            kb_clk_prev_reg <= kb_clk_sync_reg[1];
        end
    end

    assign fall   = kb_clk_prev_reg & ~kb_clk_sync_reg[1];
    assign bit_in = data_sync_reg[1];

    // After ten shifts: [0] = start bit, [8:1] = data LSB first, [9] = parity.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shift_reg      <= '0;
            bit_cnt_reg    <= '0;
            to_cnt_reg     <= '0;
            byte_reg       <= '0;
            byte_valid_reg <= 1'b0;
            frame_err_reg  <= 1'b0;
        end else begin
            byte_valid_reg <= 1'b0;
            frame_err_reg  <= 1'b0;
            if (fall) begin
                to_cnt_reg <= '0;
                if (bit_cnt_reg == 4'd10) begin
                    bit_cnt_reg <= '0;
                    if (!shift_reg[0] && bit_in && parity_ok(shift_reg[9:1])) begin
                        byte_valid_reg <= 1'b1;
                        byte_reg       <= shift_reg[8:1];
                    end else begin
                        frame_err_reg <= 1'b1;
                    end
                end else begin
                    shift_reg   <= {bit_in, shift_reg[9:1]};
                    bit_cnt_reg <= bit_cnt_reg + 4'd1;
                end
            end else if (bit_cnt_reg != 4'd0) begin
                if (to_cnt_reg == TW'(TIMEOUT_CYCLES - 1)) begin
                    bit_cnt_reg   <= '0;
                    to_cnt_reg    <= '0;
                    frame_err_reg <= 1'b1;
                end else begin
                    to_cnt_reg <= to_cnt_reg + TW'(1);
                end
            end
        end
    end

    assign rx_byte    = byte_reg;
    assign byte_valid = byte_valid_reg;
    assign frame_err  = frame_err_reg;

endmodule

// File: rtl/ps2_key_tracker.sv
// PS/2 keyboard front end: decodes E0/F0 prefixes into make/break events and
// keeps a held level plus press/release pulses for each key in KEY_CODES.
module ps2_key_tracker
    import ps2_pkg::*;
#(
    parameter int                    NUM_KEYS       = 3,
    parameter logic [9*NUM_KEYS-1:0] KEY_CODES      = {KC_SPACE, KC_DOWN, KC_UP},
    parameter int                    TIMEOUT_CYCLES = 200000,
    parameter bit                    REPEAT_PULSE   = 1'b0
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                kb_clk,
    input  logic                data,
    output logic [NUM_KEYS-1:0] held,
    output logic [NUM_KEYS-1:0] pressed,
    output logic [NUM_KEYS-1:0] released,
    output logic                frame_err
);

    logic [7:0]          rx_byte;
    logic                rx_valid;
    logic                rx_err;
    prefix_state_t       state_reg;
    prefix_state_t       state_next;
    logic                make_en;
    logic                brk_en;
    logic [8:0]          lookup_code;
    logic [NUM_KEYS-1:0] hit;
    logic [NUM_KEYS-1:0] held_reg;
    logic [NUM_KEYS-1:0] pressed_reg;
    logic [NUM_KEYS-1:0] released_reg;
    logic                is_prefix;

    ps2_rx #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_rx (
        .clk       (clk),
        .rst_n     (rst_n),
        .kb_clk    (kb_clk),
        .data      (data),
        .rx_byte   (rx_byte),
        .byte_valid(rx_valid),
        .frame_err (rx_err)
    );

    assign is_prefix = (rx_byte == SC_EXT) || (rx_byte == SC_BRK);

    always_comb begin
        state_next  = ST_IDLE;
        make_en     = 1'b0;
        brk_en      = 1'b0;
        lookup_code = {1'b0, rx_byte};
        unique case (state_reg)
            ST_IDLE: begin
                if (rx_byte == SC_EXT)      state_next = ST_EXT;
                else if (rx_byte == SC_BRK) state_next = ST_BRK;
                else                        make_en    = rx_valid;
            end
            ST_EXT: begin
                lookup_code = {1'b1, rx_byte};
                if (rx_byte == SC_BRK)      state_next = ST_EXT_BRK;
                else if (rx_byte == SC_EXT) state_next = ST_EXT;
                else                        make_en    = rx_valid;
            end
            ST_BRK: begin
                brk_en = rx_valid & ~is_prefix;
            end
            ST_EXT_BRK: begin
                lookup_code = {1'b1, rx_byte};
                brk_en      = rx_valid & ~is_prefix;
            end
            default: ;
        endcase
    end

    // A framing error discards any partially received prefix.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= ST_IDLE;
        end else if (rx_err) begin
            state_reg <= ST_IDLE;
        end else if (rx_valid) begin
            state_reg <= state_next;
        end
    end

    // Duplicate table entries all match and act together.
    for (genvar gi = 0; gi < NUM_KEYS; gi++) begin : g_cmp
        assign hit[gi] = (KEY_CODES[9*gi +: 9] == lookup_code);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            held_reg     <= '0;
            pressed_reg  <= '0;
            released_reg <= '0;
        end else begin
            pressed_reg  <= '0;
            released_reg <= '0;
            for (int i = 0; i < NUM_KEYS; i++) begin
                if (hit[i] && make_en) begin
                    if (!held_reg[i]) begin
                        held_reg[i]    <= 1'b1;
                        pressed_reg[i] <= 1'b1;
                    end else if (REPEAT_PULSE) begin
                        pressed_reg[i] <= 1'b1;
                    end
                end else if (hit[i] && brk_en && held_reg[i]) begin
                    held_reg[i]     <= 1'b0;
                    released_reg[i] <= 1'b1;
                end
            end
        end
    end

    assign held      = held_reg;
    assign pressed   = pressed_reg;
    assign released  = released_reg;
    assign frame_err = rx_err;

endmodule

// File: tb/tb_ps2_key_tracker.sv
// Bench for ps2_key_tracker: directed and random PS/2 frames into two instances
// (typematic pulse off/on) checked against a key-event model of the keyboard protocol.
module tb_ps2_key_tracker;

    localparam int HALF_BIT = 20;
    localparam int TMO      = 200;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       kb_clk = 1'b1;
    logic       data = 1'b1;
    logic [2:0] held0, pressed0, released0, held1, pressed1, released1;
    logic       frame_err0, frame_err1;

    int n_cmp = 0;
    int n_bad = 0;

    // Model state: pending prefixes, held keys and cumulative expected event counts.
    int unsigned keys[3] = '{32'h175, 32'h172, 32'h029};
    bit          m_ext = 0, m_brk = 0;
    logic [2:0]  held_m = '0;
    int          ep0[3] = '{0, 0, 0};
    int          ep1[3] = '{0, 0, 0};
    int          er[3]  = '{0, 0, 0};
    int          ee     = 0;

    // Observed cumulative event counts.
    int p0c[3] = '{0, 0, 0};
    int p1c[3] = '{0, 0, 0};
    int r0c[3] = '{0, 0, 0};
    int r1c[3] = '{0, 0, 0};
    int e0c = 0, e1c = 0;
    logic [2:0] pr0_prev = '0, pr1_prev = '0;

    always #5 clk = ~clk;

    ps2_key_tracker #(.TIMEOUT_CYCLES(TMO), .REPEAT_PULSE(1'b0)) dut0 (
        .clk(clk), .rst_n(rst_n), .kb_clk(kb_clk), .data(data),
        .held(held0), .pressed(pressed0), .released(released0), .frame_err(frame_err0)
    );

    ps2_key_tracker #(.TIMEOUT_CYCLES(TMO), .REPEAT_PULSE(1'b1)) dut1 (
        .clk(clk), .rst_n(rst_n), .kb_clk(kb_clk), .data(data),
        .held(held1), .pressed(pressed1), .released(released1), .frame_err(frame_err1)
    );

    task automatic cmp(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    always @(negedge clk) begin
        for (int i = 0; i < 3; i++) begin
            if (pressed0[i])  p0c[i]++;
            if (pressed1[i])  p1c[i]++;
            if (released0[i]) r0c[i]++;
            if (released1[i]) r1c[i]++;
        end
        if (frame_err0) e0c++;
        if (frame_err1) e1c++;
        if (pressed0 != 3'b000) cmp("pulse_width0", 32'(pressed0 & pr0_prev), 32'd0);
        if (pressed1 != 3'b000) cmp("pulse_width1", 32'(pressed1 & pr1_prev), 32'd0);
        pr0_prev = pressed0;
        pr1_prev = pressed1;
    end

    task automatic wait_clk(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // err_kind: 0 clean, 1 bad parity, 2 bad stop, 3 bad start. nbits < 11 stalls the frame.
    task automatic send_frame(input logic [7:0] b, input int err_kind, input int nbits, input bit lat);
        logic [10:0] fb;
        fb[0]    = (err_kind == 3);
        fb[8:1]  = b;
        fb[9]    = ~(^b) ^ (err_kind == 1);
        fb[10]   = (err_kind != 2);
        for (int i = 0; i < nbits; i++) begin
            data = fb[i];
            wait_clk(HALF_BIT / 2);
            kb_clk = 1'b0;
            if (lat && i == 10) begin
                wait_clk(3);
                cmp("latency_early", 32'(pressed0), 32'd0);
                wait_clk(1);
                cmp("latency_4clk", 32'(pressed0), 32'h4);
                wait_clk(HALF_BIT - 4);
            end else begin
                wait_clk(HALF_BIT);
            end
            kb_clk = 1'b1;
            wait_clk(HALF_BIT / 2);
        end
        data = 1'b1;
    endtask

    task automatic model_clear();
        m_ext = 0;
        m_brk = 0;
    endtask

    task automatic model_byte(input logic [7:0] b, input int err_kind);
        int unsigned code;
        if (err_kind != 0) begin
            ee++;
            model_clear();
        end else if (b == 8'hE0) begin
            if (m_brk) model_clear();
            else       m_ext = 1;
        end else if (b == 8'hF0) begin
            if (m_brk) model_clear();
            else       m_brk = 1;
        end else begin
            code = {23'd0, m_ext, b};
            for (int k = 0; k < 3; k++) begin
                if (keys[k] == code) begin
                    if (!m_brk) begin
                        if (!held_m[k]) begin
                            held_m[k] = 1'b1;
                            ep0[k]++;
                        end
                        ep1[k]++;
                    end else if (held_m[k]) begin
                        held_m[k] = 1'b0;
                        er[k]++;
                    end
                end
            end
            model_clear();
        end
    endtask

    task automatic check_all(input string tag);
        wait_clk(30);
        cmp({tag, "_held0"}, 32'(held0), 32'(held_m));
        cmp({tag, "_held1"}, 32'(held1), 32'(held_m));
        for (int k = 0; k < 3; k++) begin
            cmp({tag, "_press0"}, 32'(p0c[k]), 32'(ep0[k]));
            cmp({tag, "_press1"}, 32'(p1c[k]), 32'(ep1[k]));
            cmp({tag, "_rel0"}, 32'(r0c[k]), 32'(er[k]));
            cmp({tag, "_rel1"}, 32'(r1c[k]), 32'(er[k]));
        end
        cmp({tag, "_err0"}, 32'(e0c), 32'(ee));
        cmp({tag, "_err1"}, 32'(e1c), 32'(ee));
    endtask

    task automatic send_byte(input logic [7:0] b, input int err_kind);
        send_frame(b, err_kind, 11, 1'b0);
        model_byte(b, err_kind);
    endtask

    initial begin
        int p1_before, p0_before, kind;
        logic [7:0] rb;

        wait_clk(3);
        cmp("reset_state", 32'({held0, pressed0, released0, frame_err0, held1, pressed1, released1, frame_err1}), 32'd0);
        rst_n = 1'b1;
        wait_clk(5);

        send_frame(8'h29, 0, 11, 1'b1);
        model_byte(8'h29, 0);
        check_all("make29");
        cmp("lit_held_100", 32'(held0), 32'h4);

        send_byte(8'hF0, 0);
        send_byte(8'h29, 0);
        check_all("brk29");
        cmp("lit_held_000", 32'(held0), 32'h0);
        cmp("lit_rel2_once", 32'(r0c[2]), 32'd1);

        send_byte(8'hE0, 0);
        send_byte(8'h75, 0);
        check_all("up");
        cmp("lit_held_001", 32'(held0), 32'h1);
        send_byte(8'h75, 0);
        check_all("kp8");
        cmp("lit_kp8_nochange", 32'(held0), 32'h1);

        send_byte(8'hE0, 0);
        send_byte(8'h72, 0);
        send_byte(8'hE0, 0);
        send_byte(8'hF0, 0);
        send_byte(8'h75, 0);
        check_all("seq");
        cmp("lit_held_010", 32'(held0), 32'h2);
        cmp("lit_rel0_once", 32'(r0c[0]), 32'd1);

        p0_before = p0c[2];
        p1_before = p1c[2];
        for (int i = 0; i < 3; i++) send_byte(8'h29, 0);
        check_all("repeat");
        cmp("lit_rep0_single", 32'(p0c[2] - p0_before), 32'd1);
        cmp("lit_rep1_three", 32'(p1c[2] - p1_before), 32'd3);

        send_byte(8'h29, 1);
        check_all("badpar");
        cmp("lit_badpar_held", 32'(held0), 32'h6);

        send_byte(8'hF0, 0);
        send_byte(8'h29, 0);
        send_byte(8'hF0, 0);
        send_frame(8'h29, 0, 4, 1'b0);
        wait_clk(TMO + 100);
        ee++;
        model_clear();
        check_all("timeout");
        send_byte(8'h29, 0);
        check_all("after_tmo");
        cmp("lit_tmo_press", 32'(held0), 32'h6);

        send_byte(8'hE0, 0);
        send_byte(8'h75, 0);
        check_all("all_held");
        cmp("lit_held_111", 32'(held0), 32'h7);
        send_frame(8'h29, 0, 5, 1'b0);
        #3;
        rst_n = 1'b0;
        #1;
        cmp("async_reset", 32'({held0, pressed0, released0, frame_err0, held1, pressed1, released1, frame_err1}), 32'd0);
        held_m = '0;
        model_clear();
        wait_clk(5);
        #2;
        rst_n = 1'b1;
        wait_clk(5);
        send_byte(8'hF0, 0);
        send_byte(8'h29, 0);
        check_all("rel_after_rst");
        send_byte(8'h29, 0);
        check_all("press_after_rst");

        for (int n = 0; n < 40; n++) begin
            case ($urandom_range(0, 7))
                0:       rb = 8'hE0;
                1, 7:    rb = 8'hF0;
                2:       rb = 8'h29;
                3:       rb = 8'h72;
                4:       rb = 8'h75;
                5:       rb = 8'hAA;
                default: rb = 8'($urandom);
            endcase
            kind = ($urandom_range(0, 9) == 0) ? int'($urandom_range(1, 3)) : 0;
            send_byte(rb, kind);
            check_all("rand");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
